// File: rtl/ws2812_pkg.sv
// rtl/ws2812_pkg.sv - shared constants and FSM encoding for the WS2812 frame buffer
//
// Purpose: frame geometry defaults and the controller state type, imported by
//          ws2812_pix_ram and ws2812_frame_buf.
// Contents: NUM_PIX (pixels per frame), COLOR_W (bits per GRB pixel),
//           fb_state_t (IDLE / CLEAR / WAIT_SWAP).
package ws2812_pkg;

  localparam int NUM_PIX = 64;
  localparam int COLOR_W = 24;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_CLEAR     = 2'd1,
    ST_WAIT_SWAP = 2'd2
  } fb_state_t;

endpackage

// File: rtl/ws2812_pix_ram.sv
// rtl/ws2812_pix_ram.sv - one pixel bank, synchronous write, asynchronous read
//
// Purpose: DEPTH x WIDTH storage for one frame bank. Contents are not reset.
// Ports:
//   sys_clk  - write clock (rising edge)
//   we       - write enable
//   waddr    - write address
//   wdata    - write data
//   raddr    - read address (combinational read)
//   rdata    - read data
module ws2812_pix_ram
  import ws2812_pkg::*;
#(
  parameter int  DEPTH  = NUM_PIX,
  parameter int  WIDTH  = COLOR_W,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              sys_clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge sys_clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ws2812_frame_buf.sv
// rtl/ws2812_frame_buf.sv - double-buffered WS2812 pixel frame store with serial bit tap
//
// Purpose: two pixel banks; the host fills the back bank while the serializer
//          reads the active bank bit by bit. A swap is armed by swap_req and
//          takes effect at the next frame wrap (cnt_pixel 63 -> 0).
// Ports:
//   sys_clk, sys_rst_n  - clock, asynchronous active-low reset
//   wr_en/wr_addr/wr_data - back-bank pixel write (accepted when wr_ready)
//   wr_ready            - high only while the controller is idle
//   clr_req             - pulse: zero-fill the back bank (one pixel per cycle)
//   swap_req            - pulse: exchange banks at the next frame wrap
//   cnt_bit, cnt_pixel  - serializer position (bit within pixel, pixel index)
//   ser_bit             - combinational data bit for the serializer, MSB first
//   frame_done          - one-cycle pulse after a swap has taken effect
module ws2812_frame_buf #(
  parameter int  NUM_PIX = ws2812_pkg::NUM_PIX,
  parameter int  COLOR_W = ws2812_pkg::COLOR_W,
  localparam int ADDR_W  = $clog2(NUM_PIX),
  localparam int BIT_W   = $clog2(COLOR_W)
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic               wr_en,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [COLOR_W-1:0] wr_data,
  output logic               wr_ready,
  input  logic               clr_req,
  input  logic               swap_req,
  input  logic [BIT_W-1:0]   cnt_bit,
  input  logic [ADDR_W:0]    cnt_pixel,
  output logic               ser_bit,
  output logic               frame_done
);
  import ws2812_pkg::*;

  fb_state_t          state_q, state_d;
  logic               active_q;      // 0: bank 0 is read, bank 1 is written
  logic               shown_q;       // masks uninitialised RAM until first swap
  logic [ADDR_W:0]    prev_pix_q;
  logic [ADDR_W-1:0]  clr_addr_q;
  logic               frame_done_q;

  logic               wrap;
  logic               swap_go;
  logic               back_we;
  logic [ADDR_W-1:0]  back_addr;
  logic [COLOR_W-1:0] back_data;
  logic [COLOR_W-1:0] rdata0, rdata1, act_rdata;
  logic [BIT_W-1:0]   bit_idx;
  logic               clr_last;

  assign wrap     = (prev_pix_q == (ADDR_W+1)'(NUM_PIX-1)) && (cnt_pixel == '0);
  assign clr_last = (clr_addr_q == ADDR_W'(NUM_PIX-1));

  always_comb begin
    state_d   = state_q;
    swap_go   = 1'b0;
    back_we   = 1'b0;
    back_addr = wr_addr;
    back_data = wr_data;
    case (state_q)
      ST_IDLE: begin
        back_we = wr_en;
        // clear wins over swap; a write in the same cycle still lands
        if (clr_req) begin
          state_d = ST_CLEAR;
        end else if (swap_req) begin
          state_d = ST_WAIT_SWAP;
        end
      end
      ST_CLEAR: begin
        back_we   = 1'b1;
        back_addr = clr_addr_q;
        back_data = '0;
        if (clr_last) begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT_SWAP: begin
        if (wrap) begin
          swap_go = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q      <= ST_IDLE;
      active_q     <= 1'b0;
      shown_q      <= 1'b0;
      prev_pix_q   <= '0;
      clr_addr_q   <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      prev_pix_q   <= cnt_pixel;
      frame_done_q <= swap_go;
      if (swap_go) begin
        active_q <= ~active_q;
        shown_q  <= 1'b1;
      end
      if (state_q == ST_CLEAR) begin
        clr_addr_q <= clr_last ? '0 : clr_addr_q + 1'b1;
      end
    end
  end

  // Only the bank opposite the active one ever sees a write enable.
  ws2812_pix_ram #(.DEPTH(NUM_PIX), .WIDTH(COLOR_W)) u_bank0 (
    .sys_clk (sys_clk),
    .we      (back_we & active_q),
    .waddr   (back_addr),
    .wdata   (back_data),
    .raddr   (cnt_pixel[ADDR_W-1:0]),
    .rdata   (rdata0)
  );

  ws2812_pix_ram #(.DEPTH(NUM_PIX), .WIDTH(COLOR_W)) u_bank1 (
    .sys_clk (sys_clk),
    .we      (back_we & ~active_q),
    .waddr   (back_addr),
    .wdata   (back_data),
    .raddr   (cnt_pixel[ADDR_W-1:0]),
    .rdata   (rdata1)
  );

  assign act_rdata = active_q ? rdata1 : rdata0;
  assign bit_idx   = BIT_W'(COLOR_W-1) - cnt_bit;

  always_comb begin
    ser_bit = 1'b0;
    if (shown_q && (cnt_pixel < (ADDR_W+1)'(NUM_PIX)) && (cnt_bit < BIT_W'(COLOR_W))) begin
      ser_bit = act_rdata[bit_idx];
    end
  end

  assign wr_ready   = (state_q == ST_IDLE);
  assign frame_done = frame_done_q;

endmodule
